// File: rtl/pt_dec.sv
// PT2262-style receiver: measures on/off-keyed pulse widths and rebuilds the
// 12-codebit (24-bit) word, strobing valid on a clean frame and err on abort.
module pt_dec #(
  parameter int TICK_DIV  = 1,
  parameter int SHORT_MIN = 2,
  parameter int SHORT_MAX = 6,
  parameter int LONG_MIN  = 9,
  parameter int LONG_MAX  = 15,
  parameter int SYNC_MIN  = 64,
  parameter int CW        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] ad,
  output logic        valid,
  output logic        err,
  output logic        busy
);

  localparam logic [CW-1:0] S_LO = CW'(SHORT_MIN * TICK_DIV);
  localparam logic [CW-1:0] S_HI = CW'(SHORT_MAX * TICK_DIV);
  localparam logic [CW-1:0] L_LO = CW'(LONG_MIN * TICK_DIV);
  localparam logic [CW-1:0] L_HI = CW'(LONG_MAX * TICK_DIV);
  localparam logic [CW-1:0] SYN  = CW'(SYNC_MIN * TICK_DIV);

  typedef enum logic [2:0] {WAIT_GAP, ARMED, HIGH, LOW, SYNC_H, SYNC_L, ERR} state_t;

  state_t        state, state_nx;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [23:0]   sr, dec;
  logic [4:0]    pcnt, pcnt_nx;
  logic          hcls, hcls_nx, busy_nx, shift, load, bad;
  logic          rise, fall, w_s, w_l, tmo;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign w_s  = (cnt >= S_LO) && (cnt <= S_HI);
  assign w_l  = (cnt >= L_LO) && (cnt <= L_HI);
  assign tmo  = cnt > L_HI;

  // The edge cycle is the first cycle of the new run, so the count restarts at 1
  // and reads the exact run length when the next edge is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (s2 ^ s3)     cnt <= CW'(1);
      else if (~&cnt)  cnt <= cnt + CW'(1);
    end
  end

  // Raw class pair (first,second) -> code {f^s, f}; L,S lands on 11 and is rejected.
  always_comb begin
    dec = '0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      dec[2*k+1] = sr[2*k+1] ^ sr[2*k];
      dec[2*k]   = sr[2*k+1];
      bad        = bad | (sr[2*k+1] & ~sr[2*k]);
    end
  end

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    hcls_nx  = hcls;
    busy_nx  = busy;
    shift    = 1'b0;
    load     = 1'b0;
    case (state)
      WAIT_GAP: if (!s2 && !s3 && cnt >= SYN) state_nx = ARMED;
      ARMED: if (rise) begin
        state_nx = HIGH;
        busy_nx  = 1'b1;
        pcnt_nx  = '0;
      end
      HIGH: begin
        if (fall) begin
          if (w_s)      begin hcls_nx = 1'b0; state_nx = LOW; end
          else if (w_l) begin hcls_nx = 1'b1; state_nx = LOW; end
          else          state_nx = ERR;
        end else if (tmo) state_nx = ERR;
      end
      LOW: begin
        if (rise) begin
          if (hcls ? w_s : w_l) begin
            shift    = 1'b1;
            pcnt_nx  = pcnt + 5'd1;
            state_nx = (pcnt == 5'd23) ? SYNC_H : HIGH;
          end else state_nx = ERR;
        end else if (tmo) state_nx = ERR;
      end
      SYNC_H: begin
        if (fall)     state_nx = w_s ? SYNC_L : ERR;
        else if (tmo) state_nx = ERR;
      end
      SYNC_L: begin
        if (rise) state_nx = ERR;
        else if (cnt >= SYN) begin
          if (bad) state_nx = ERR;
          else begin
            load     = 1'b1;
            busy_nx  = 1'b0;
            state_nx = ARMED;
          end
        end
      end
      ERR:     state_nx = WAIT_GAP;
      default: state_nx = WAIT_GAP;
    endcase
    if (state_nx == ERR) busy_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_GAP;
      pcnt  <= '0;
      hcls  <= 1'b0;
      sr    <= '0;
      ad    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
      hcls  <= hcls_nx;
      busy  <= busy_nx;
      valid <= load;
      err   <= (state_nx == ERR);
      if (shift) sr <= {sr[22:0], hcls};
      if (load)  ad <= dec;
    end
  end

endmodule

// File: tb/tb_pt_dec.sv
// Randomized frame bench for pt_dec: widths are generated per tick, and a
// class-level reference model predicts valid/err/ad for each frame.
module tb_pt_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0, din4 = 1'b0;
  logic [23:0] ad, ad4;
  logic        valid, err, busy, valid4, err4, busy4;

  pt_dec dut (.clk(clk), .rst(rst), .din(din), .ad(ad), .valid(valid), .err(err), .busy(busy));
  pt_dec #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .din(din4), .ad(ad4), .valid(valid4),
                               .err(err4), .busy(busy4));

  always #5 clk = ~clk;

  int checks = 0, errs = 0;
  int vcnt = 0, ecnt = 0, both = 0, vcnt4 = 0, ecnt4 = 0, both4 = 0;
  int hw[25], lw[25];
  logic [23:0] exp_ad = '0;

  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err) ecnt++;
    if (valid && err) both++;
    if (valid4) vcnt4++;
    if (err4) ecnt4++;
    if (valid4 && err4) both4++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 = short, 1 = long, 2 = neither (ticks, TICK_DIV = 1 reference)
  function automatic int wclass(input int w);
    if (w >= 2 && w <= 6) return 0;
    if (w >= 9 && w <= 15) return 1;
    return 2;
  endfunction

  function automatic int rw(input int c, input bit nominal);
    if (nominal) return c ? 12 : 4;
    return c ? int'($urandom_range(15, 9)) : int'($urandom_range(6, 2));
  endfunction

  // Build pulse widths for a word; fault: 1 bad high, 2 same-class low,
  // 3 L,S codebit, 4 long sync high, 5 low timeout.
  task automatic gen(input logic [23:0] code, input bit nominal, input int fault, input int j);
    for (int k = 0; k < 12; k++) begin
      logic [1:0] c;
      int f, s;
      c = code[23-2*k -: 2];
      f = (c == 2'b01) ? 1 : 0;
      s = (c == 2'b00) ? 0 : 1;
      hw[2*k] = rw(f, nominal);   lw[2*k] = rw(1 - f, nominal);
      hw[2*k+1] = rw(s, nominal); lw[2*k+1] = rw(1 - s, nominal);
    end
    hw[24] = rw(0, nominal);
    lw[24] = nominal ? 124 : int'($urandom_range(130, 80));
    case (fault)
      1: hw[j] = 7;
      2: lw[j] = rw(wclass(hw[j]), nominal);
      3: begin
        hw[2*(j/2)] = rw(1, nominal);   lw[2*(j/2)] = rw(0, nominal);
        hw[2*(j/2)+1] = rw(0, nominal); lw[2*(j/2)+1] = rw(1, nominal);
      end
      4: hw[24] = rw(1, nominal);
      5: lw[j] = $urandom_range(20, 16);
      default: ;
    endcase
  endtask

  task automatic model(output bit ok, output logic [23:0] word);
    int cls[24];
    ok = 1'b1;
    word = '0;
    for (int i = 0; i < 24; i++) begin
      int h, l;
      h = wclass(hw[i]);
      l = wclass(lw[i]);
      if (h == 2 || l == 2 || h == l) ok = 1'b0;
      cls[i] = h;
    end
    if (wclass(hw[24]) != 0) ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (cls[2*k] == 1 && cls[2*k+1] == 0) ok = 1'b0;
      else if (cls[2*k] == 1)               word[23-2*k -: 2] = 2'b01;
      else if (cls[2*k+1] == 1)             word[23-2*k -: 2] = 2'b10;
      else                                  word[23-2*k -: 2] = 2'b00;
    end
  endtask

  task automatic hold(input bit which, input logic lv, input int n);
    if (which) din4 = lv; else din = lv;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit which, input int td, input int rst_at, input bit busy_chk);
    for (int i = 0; i < 25; i++) begin
      if (i == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ad", ad, 24'h0);
        chk("rst_busy", busy, 1'b0);
        #1 rst = 1'b0;
      end
      if (i == 12 && busy_chk) chk("busy_mid", busy, 1'b1);
      hold(which, 1'b1, hw[i] * td);
      hold(which, 1'b0, lw[i] * td);
    end
  endtask

  task automatic frame(input string tag, input int rst_at, input bit busy_chk);
    bit ok;
    logic [23:0] word;
    int v0, e0;
    model(ok, word);
    v0 = vcnt;
    e0 = ecnt;
    send(1'b0, 1, rst_at, busy_chk);
    if (rst_at >= 0) begin
      exp_ad = '0;
      chk({tag, "_valid"}, vcnt - v0, 0);
      chk({tag, "_err"}, ecnt - e0, 0);
    end else if (ok) begin
      exp_ad = word;
      chk({tag, "_valid"}, vcnt - v0, 1);
      chk({tag, "_err"}, ecnt - e0, 0);
    end else begin
      chk({tag, "_valid"}, vcnt - v0, 0);
      chk({tag, "_err"}, ecnt - e0, 1);
    end
    chk({tag, "_ad"}, ad, exp_ad);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int lat, v0, e0;
    repeat (3) @(negedge clk);
    chk("reset_ad", ad, 24'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b0, 1'b0, 100);

    // Nominal encoder frames, back to back
    gen(24'h169A45, 1'b1, 0, 0);
    frame("enc1", -1, 1'b1);
    chk("enc1_word", ad, 24'h169A45);
    gen(24'h2A0551, 1'b1, 0, 0);
    frame("enc2", -1, 1'b0);
    chk("enc2_word", ad, 24'h2A0551);

    // 5th codebit sent as L,S: rejected at the sync gap, then a clean frame
    gen(24'h155555, 1'b1, 3, 8);
    frame("ls_bad", -1, 1'b0);
    gen(24'h0A2814, 1'b1, 0, 0);
    frame("ls_next", -1, 1'b0);

    // A 7-tick high pulse, then a 70-tick low gap
    gen(24'h000000, 1'b1, 0, 0);
    v0 = vcnt;
    e0 = ecnt;
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 1'b1, hw[i]);
      hold(1'b0, 1'b0, lw[i]);
    end
    hold(1'b0, 1'b1, 7);
    din = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err) begin lat = i; break; end
    end
    chk("w7_err_latency", lat, 3);
    hold(1'b0, 1'b0, 70 - lat);
    chk("w7_err_count", ecnt - e0, 1);
    chk("w7_valid", vcnt - v0, 0);
    gen(24'h2A1504, 1'b1, 0, 0);
    frame("w7_next", -1, 1'b0);

    // Async reset at pulse 10, then a full frame
    gen(24'h154A21, 1'b1, 0, 0);
    frame("rst_mid", 10, 1'b0);
    gen(24'h091A45, 1'b1, 0, 0);
    frame("rst_next", -1, 1'b0);

    // Randomized frames with jittered widths and occasional faults
    for (int n = 0; n < 14; n++) begin
      logic [23:0] code;
      int fault;
      for (int k = 0; k < 12; k++) begin
        int c;
        c = $urandom_range(2, 0);
        code[23-2*k -: 2] = 2'(c);
      end
      fault = ($urandom_range(9, 0) < 4) ? int'($urandom_range(5, 1)) : 0;
      gen(code, 1'b0, fault, $urandom_range(23, 0));
      frame($sformatf("rnd%0d_f%0d", n, fault), -1, 1'b0);
    end

    // TICK_DIV = 4 instance: 4x stimulus decodes, 1x stimulus aborts
    hold(1'b1, 1'b0, 300);
    gen(24'h000000, 1'b1, 0, 0);
    v0 = vcnt4;
    e0 = ecnt4;
    send(1'b1, 4, -1, 1'b0);
    chk("td4_valid", vcnt4 - v0, 1);
    chk("td4_err", ecnt4 - e0, 0);
    chk("td4_ad", ad4, 24'h0);
    v0 = vcnt4;
    e0 = ecnt4;
    send(1'b1, 1, -1, 1'b0);
    hold(1'b1, 1'b0, 300);
    chk("td4_1x_valid", vcnt4 - v0, 0);
    chk("td4_1x_err", ecnt4 - e0, 1);

    chk("excl", both, 0);
    chk("excl4", both4, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
